// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// adc_seq_pkg
// Shared types, XADC DRP addresses and sample conversion for the ADC sequencer.
// Revision: 1.0
// ============================================================================
package adc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } seq_state_t;

    localparam logic [6:0] VAUX3_ADDR  = 7'h13;
    localparam logic [6:0] VAUX11_ADDR = 7'h1B;

    // XADC bipolar results are offset binary; flipping the MSB yields two's complement.
    function automatic logic [11:0] offset_to_twos(input logic [11:0] raw);
        return {~raw[11], raw[10:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// sample_tick_gen
// Free-running 0..SAMPLE_COUNT counter producing a one-cycle sample tick.
// Revision: 1.0
// ============================================================================
module sample_tick_gen #(
    parameter int SAMPLE_COUNT = 2082
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic enable_in,
    output logic tick_out
);

    localparam int CNT_W = (SAMPLE_COUNT > 0) ? $clog2(SAMPLE_COUNT + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_top;

    assign at_top   = (cnt_q == CNT_W'(SAMPLE_COUNT));
    assign tick_out = at_top & enable_in;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable_in || at_top) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_sample_sequencer.sv
`default_nettype none
// ============================================================================
// adc_sample_sequencer
// Ticks at the audio rate and reads one or two XADC aux channels over DRP.
// Revision: 1.0
// ============================================================================
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int         SAMPLE_COUNT = 2082,
    parameter int         TIMEOUT      = 64,
    parameter logic [6:0] CH0_ADDR     = VAUX3_ADDR,
    parameter logic [6:0] CH1_ADDR     = VAUX11_ADDR
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic        dual_ch_in,
    input  logic        clr_status_in,
    output logic        drp_den_out,
    output logic [6:0]  drp_daddr_out,
    output logic        drp_dwe_out,
    input  logic [15:0] drp_do_in,
    input  logic        drp_drdy_in,
    output logic        tick_out,
    output logic [11:0] sample_out,
    output logic        sample_ch_out,
    output logic        sample_valid_out,
    output logic        overrun_out,
    output logic        timeout_out
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_t        state_q;
    logic              ch_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              den_q;
    logic [6:0]        daddr_q;
    logic [11:0]       sample_q;
    logic              sample_ch_q;
    logic              valid_q;
    logic              overrun_q;
    logic              timeout_q;

    logic tick;
    logic wait_expired;
    logic timeout_set;
    logic overrun_set;
    logic unused_do_lsb;

    sample_tick_gen #(
        .SAMPLE_COUNT (SAMPLE_COUNT)
    ) u_tick_gen (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .enable_in (enable_in),
        .tick_out  (tick)
    );

    assign unused_do_lsb = ^drp_do_in[3:0];

    // A drdy on the last allowed WAIT cycle takes priority over the timeout.
    assign wait_expired = (wcnt_q == WCNT_W'(TIMEOUT - 1));
    assign timeout_set  = (state_q == S_WAIT) & ~drp_drdy_in & wait_expired;
    assign overrun_set  = tick & (state_q != S_IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            ch_q        <= 1'b0;
            wcnt_q      <= '0;
            den_q       <= 1'b0;
            daddr_q     <= '0;
            sample_q    <= '0;
            sample_ch_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            den_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= overrun_set | (overrun_q & ~clr_status_in);
            timeout_q <= timeout_set | (timeout_q & ~clr_status_in);

            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        ch_q    <= 1'b0;
                        daddr_q <= CH0_ADDR;
                        den_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wcnt_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (drp_drdy_in) begin
                        sample_q    <= offset_to_twos(drp_do_in[15:4]);
                        sample_ch_q <= ch_q;
                        valid_q     <= 1'b1;
                        state_q     <= S_CAPTURE;
                    end else if (wait_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (dual_ch_in && !ch_q) begin
                        ch_q    <= 1'b1;
                        daddr_q <= CH1_ADDR;
                        den_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tick_out         = tick;
    assign drp_den_out      = den_q;
    assign drp_daddr_out    = daddr_q;
    assign drp_dwe_out      = 1'b0;
    assign sample_out       = sample_q;
    assign sample_ch_out    = sample_ch_q;
    assign sample_valid_out = valid_q;
    assign overrun_out      = overrun_q;
    assign timeout_out      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_sequencer.sv
`default_nettype none
// ============================================================================
// tb_adc_sample_sequencer
// Event-timestamp reference model plus directed and randomized stimulus.
// Revision: 1.0
// ============================================================================
module tb_adc_sample_sequencer;

    localparam int         SC   = 15;
    localparam int         TO   = 8;
    localparam logic [6:0] CH0A = 7'h13;
    localparam logic [6:0] CH1A = 7'h1B;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        enable_in = 1'b0;
    logic        dual_ch_in = 1'b0;
    logic        clr_status_in = 1'b0;
    logic        drp_den_out;
    logic [6:0]  drp_daddr_out;
    logic        drp_dwe_out;
    logic [15:0] drp_do_in = '0;
    logic        drp_drdy_in = 1'b0;
    logic        tick_out;
    logic [11:0] sample_out;
    logic        sample_ch_out;
    logic        sample_valid_out;
    logic        overrun_out;
    logic        timeout_out;

    adc_sample_sequencer #(
        .SAMPLE_COUNT (SC),
        .TIMEOUT      (TO)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .enable_in        (enable_in),
        .dual_ch_in       (dual_ch_in),
        .clr_status_in    (clr_status_in),
        .drp_den_out      (drp_den_out),
        .drp_daddr_out    (drp_daddr_out),
        .drp_dwe_out      (drp_dwe_out),
        .drp_do_in        (drp_do_in),
        .drp_drdy_in      (drp_drdy_in),
        .tick_out         (tick_out),
        .sample_out       (sample_out),
        .sample_ch_out    (sample_ch_out),
        .sample_valid_out (sample_valid_out),
        .overrun_out      (overrun_out),
        .timeout_out      (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // DRP responder: drdy resp_delay cycles after den (0 = never), optional noise.
    int          resp_delay = 3;
    int          drdy_due   = -1;
    bit          noise_en   = 1'b0;
    bit          rand_data  = 1'b0;
    logic [6:0]  resp_addr  = '0;
    logic [15:0] d13 = 16'h0000;
    logic [15:0] d1b = 16'h0000;

    always @(posedge clk_in) begin
        #1;
        if (!rst_n_in) begin
            drp_drdy_in = 1'b0;
        end else begin
            drp_drdy_in = (cyc == drdy_due) || (noise_en && ($urandom_range(0, 5) == 0));
            drp_do_in   = rand_data ? 16'($urandom) : ((resp_addr == CH1A) ? d1b : d13);
        end
    end

    // Logs of observed DUT events for the directed literal checks.
    logic [6:0]  den_addr[$];
    int          den_cyc[$];
    logic [11:0] val_smp[$];
    logic        val_ch[$];
    int          val_cyc[$];
    int          n_tick = 0;

    // Reference model: sequences tracked as event timestamps.
    int          m_cnt = 0;
    bit          m_busy = 1'b0;
    bit          m_win = 1'b0;
    int          m_win_hi = 0;
    int          m_den_at = -1;
    int          m_val_at = -1;
    bit          m_ch = 1'b0;
    logic        e_den = 1'b0;
    logic [6:0]  e_addr = '0;
    logic        e_valid = 1'b0;
    logic [11:0] e_smp = '0;
    logic        e_sch = 1'b0;
    logic        e_ovr = 1'b0;
    logic        e_to = 1'b0;

    always @(negedge clk_in) begin
        bit          w_tick;
        bit          busy_c;
        bit          ovr_set;
        bit          to_set;
        logic [11:0] n_smp;
        logic        n_sch;
        if (!rst_n_in) begin
            m_cnt = 0; m_busy = 0; m_win = 0; m_den_at = -1; m_val_at = -1; m_ch = 0;
            e_den = 0; e_addr = '0; e_valid = 0; e_smp = '0; e_sch = 0; e_ovr = 0; e_to = 0;
            drdy_due = -1;
        end
        w_tick = enable_in && (m_cnt == SC);
        chk("tick",    32'(tick_out),         32'(w_tick));
        chk("den",     32'(drp_den_out),      32'(e_den));
        chk("daddr",   32'(drp_daddr_out),    32'(e_addr));
        chk("dwe",     32'(drp_dwe_out),      32'(0));
        chk("valid",   32'(sample_valid_out), 32'(e_valid));
        chk("sample",  32'(sample_out),       32'(e_smp));
        chk("ch",      32'(sample_ch_out),    32'(e_sch));
        chk("overrun", 32'(overrun_out),      32'(e_ovr));
        chk("timeout", 32'(timeout_out),      32'(e_to));

        if (rst_n_in) begin
            if (tick_out) n_tick++;
            if (drp_den_out) begin
                den_addr.push_back(drp_daddr_out);
                den_cyc.push_back(cyc);
                resp_addr = drp_daddr_out;
                drdy_due  = (resp_delay > 0) ? cyc + resp_delay : -1;
            end
            if (sample_valid_out) begin
                val_smp.push_back(sample_out);
                val_ch.push_back(sample_ch_out);
                val_cyc.push_back(cyc);
            end

            busy_c  = m_busy;
            ovr_set = w_tick && busy_c;
            to_set  = 0;
            n_smp   = e_smp;
            n_sch   = e_sch;
            if (m_win) begin
                if (drp_drdy_in) begin
                    m_win    = 0;
                    m_val_at = cyc + 1;
                    n_smp    = drp_do_in[15:4] - 12'd2048;
                    n_sch    = m_ch;
                end else if (cyc == m_win_hi) begin
                    m_win  = 0;
                    to_set = 1;
                    m_busy = 0;
                end
            end
            if (cyc == m_den_at) begin
                m_win    = 1;
                m_win_hi = cyc + TO;
            end
            if (cyc == m_val_at) begin
                if (dual_ch_in && !m_ch) begin
                    m_ch     = 1;
                    m_den_at = cyc + 1;
                    e_addr   = CH1A;
                end else begin
                    m_busy = 0;
                end
            end
            if (!busy_c && w_tick) begin
                m_busy   = 1;
                m_ch     = 0;
                m_den_at = cyc + 1;
                e_addr   = CH0A;
            end
            e_den   = (m_den_at == cyc + 1);
            e_valid = (m_val_at == cyc + 1);
            if (e_valid) begin
                e_smp = n_smp;
                e_sch = n_sch;
            end
            e_ovr = ovr_set || (e_ovr && !clr_status_in);
            e_to  = to_set  || (e_to  && !clr_status_in);
            m_cnt = enable_in ? (m_cnt + 1) % (SC + 1) : 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic clear_logs();
        den_addr.delete(); den_cyc.delete();
        val_smp.delete(); val_ch.delete(); val_cyc.delete();
        n_tick = 0;
    endtask

    task automatic quiesce();
        enable_in = 0;
        noise_en  = 0;
        step(30);
    endtask

    task automatic pulse_clr();
        clr_status_in = 1;
        step(1);
        clr_status_in = 0;
    endtask

    task automatic wait_den(input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (drp_den_out) begin
                found = 1;
                break;
            end
        end
        chk("wait_den_found", 32'(found), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int t;
        bit hit;

        // Reset state
        step(3);
        chk("rst_den",     32'(drp_den_out),      32'(0));
        chk("rst_daddr",   32'(drp_daddr_out),    32'(0));
        chk("rst_valid",   32'(sample_valid_out), 32'(0));
        chk("rst_sample",  32'(sample_out),       32'(0));
        chk("rst_flags",   32'({overrun_out, timeout_out}), 32'(0));
        rst_n_in = 1;
        step(2);

        // Single channel, full-scale positive then negative
        d13 = 16'hFFF0; resp_delay = 3; dual_ch_in = 0;
        clear_logs();
        enable_in = 1;
        step(40);
        chk("single_n_den", 32'(den_addr.size()), 32'(2));
        chk("single_addr",  32'(den_addr[0]), 32'(7'h13));
        chk("single_period", 32'(den_cyc[1] - den_cyc[0]), 32'(16));
        chk("single_lat",   32'(val_cyc[0] - den_cyc[0]), 32'(4));
        chk("single_7ff",   32'(val_smp[$]), 32'(12'h7FF));
        chk("single_ch",    32'(val_ch[$]), 32'(0));
        d13 = 16'h0000;
        clear_logs();
        step(16);
        chk("single_zero_n", 32'(val_smp.size()), 32'(1));
        if (val_smp.size() > 0) chk("single_800", 32'(val_smp[$]), 32'(12'h800));

        // Dual channel
        quiesce();
        dual_ch_in = 1; d13 = 16'h8000; d1b = 16'h7FF0;
        clear_logs();
        enable_in = 1;
        step(32);
        chk("dual_n_valid", 32'(val_smp.size()), 32'(2));
        if (val_smp.size() == 2) begin
            chk("dual_s0", 32'(val_smp[0]), 32'(12'h000));
            chk("dual_c0", 32'(val_ch[0]),  32'(0));
            chk("dual_s1", 32'(val_smp[1]), 32'(12'hFFF));
            chk("dual_c1", 32'(val_ch[1]),  32'(1));
        end
        if (den_cyc.size() >= 2 && val_cyc.size() >= 1) begin
            chk("dual_den2_addr", 32'(den_addr[1]), 32'(7'h1B));
            chk("dual_den2_time", 32'(den_cyc[1] - val_cyc[0]), 32'(1));
        end

        // Timeout: drdy never arrives
        quiesce();
        dual_ch_in = 0; resp_delay = 0;
        clear_logs();
        enable_in = 1;
        step(34);
        chk("to_flag",   32'(timeout_out), 32'(1));
        chk("to_nvalid", 32'(val_smp.size()), 32'(0));
        chk("to_retry",  32'(den_addr.size()), 32'(2));

        // drdy on the final allowed WAIT cycle
        quiesce();
        pulse_clr();
        chk("to_clr", 32'(timeout_out), 32'(0));
        resp_delay = 8;
        clear_logs();
        enable_in = 1;
        step(30);
        chk("edge_nvalid", 32'(val_smp.size()), 32'(1));
        chk("edge_noto",   32'(timeout_out), 32'(0));
        if (val_cyc.size() > 0 && den_cyc.size() > 0)
            chk("edge_lat", 32'(val_cyc[0] - den_cyc[0]), 32'(9));

        // Overrun: dual sequence with slow drdy outlasts the tick period
        quiesce();
        dual_ch_in = 1; resp_delay = 8;
        clear_logs();
        enable_in = 1;
        step(34);
        chk("ovr_flag",  32'(overrun_out), 32'(1));
        chk("ovr_n_den", 32'(den_addr.size()), 32'(2));
        quiesce();
        pulse_clr();
        chk("ovr_clr", 32'(overrun_out), 32'(0));
        enable_in = 1;
        hit = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (enable_in && m_cnt == SC && m_busy) begin
                clr_status_in = 1;
                step(1);
                clr_status_in = 0;
                hit = 1;
                break;
            end
        end
        chk("ovr_collide_found", 32'(hit), 32'(1));
        chk("ovr_collide_flag",  32'(overrun_out), 32'(1));

        // Enable falls mid-sequence
        quiesce();
        pulse_clr();
        dual_ch_in = 0; resp_delay = 3; d13 = 16'h1230;
        enable_in = 1;
        wait_den(40);
        step(1);
        enable_in = 0;
        clear_logs();
        step(30);
        chk("en_off_nvalid", 32'(val_smp.size()), 32'(1));
        if (val_smp.size() > 0) chk("en_off_smp", 32'(val_smp[0]), 32'(12'h923));
        chk("en_off_nden",  32'(den_addr.size()), 32'(0));
        chk("en_off_ntick", 32'(n_tick), 32'(0));

        // Asynchronous reset mid-WAIT
        enable_in = 1;
        wait_den(40);
        step(1);
        rst_n_in = 0;
        #1;
        chk("arst_den",    32'(drp_den_out),      32'(0));
        chk("arst_daddr",  32'(drp_daddr_out),    32'(0));
        chk("arst_valid",  32'(sample_valid_out), 32'(0));
        chk("arst_sample", 32'(sample_out),       32'(0));
        chk("arst_tick",   32'(tick_out),         32'(0));
        step(2);
        rst_n_in = 1;
        r = cyc;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (tick_out) begin
                t = cyc;
                break;
            end
        end
        chk("first_tick_after_rst", 32'(t - r), 32'(15));

        // Randomized phase
        rand_data = 1;
        for (int k = 0; k < 40; k++) begin
            enable_in  = ($urandom_range(0, 9) < 8);
            dual_ch_in = 1'($urandom_range(0, 1));
            resp_delay = $urandom_range(0, 11);
            noise_en   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) pulse_clr();
            if ($urandom_range(0, 15) == 0) begin
                rst_n_in = 0;
                step(2);
                rst_n_in = 1;
            end
            step($urandom_range(5, 30));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
